// File: rtl/spi_burst_ram_if.sv
// -----------------------------------------------------------------------------
// spi_burst_ram_if
// Bundles the command/response signals between the SPI slave and the burst RAM.
//   din      : command word, [PAY_W+1:PAY_W] opcode, [PAY_W-1:0] payload
//   rx_valid : single-cycle strobe qualifying din
//   tx_ready : SPI transmit side accepts dout this cycle
//   dout     : read data word
//   tx_valid : dout holds a valid burst word
//   busy     : read burst in progress
//   cmd_err  : one-cycle pulse, address payload out of range
//   cmd_drop : one-cycle pulse, command rejected while busy
// Modports: slave (the RAM) and master (the SPI side).
// -----------------------------------------------------------------------------
interface spi_burst_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
);
    localparam int PAY_W = (ADDR_W > DATA_W) ? ((ADDR_W > LEN_W) ? ADDR_W : LEN_W)
                                             : ((DATA_W > LEN_W) ? DATA_W : LEN_W);

    logic [PAY_W+1:0]  din;
    logic              rx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              busy;
    logic              cmd_err;
    logic              cmd_drop;

    modport slave (
        input  din, rx_valid, tx_ready,
        output dout, tx_valid, busy, cmd_err, cmd_drop
    );

    modport master (
        output din, rx_valid, tx_ready,
        input  dout, tx_valid, busy, cmd_err, cmd_drop
    );
endinterface

// File: rtl/spi_burst_ram.sv
// -----------------------------------------------------------------------------
// spi_burst_ram
// Command-driven single-port RAM behind an SPI slave. Opcodes:
//   00 SET_WADDR, 01 WRITE (auto-increment), 10 SET_RADDR, 11 READ_BURST.
// Read bursts of 1..2^LEN_W words are returned over a tx_valid/tx_ready
// handshake. Out-of-range addresses raise cmd_err; commands arriving during a
// burst are rejected with cmd_drop.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : spi_burst_ram_if.slave (din, rx_valid, tx_ready in;
//           dout, tx_valid, busy, cmd_err, cmd_drop out)
// -----------------------------------------------------------------------------
module spi_burst_ram #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int LEN_W     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_burst_ram_if.slave  bus
);

    localparam int PAY_W = (ADDR_W > DATA_W) ? ((ADDR_W > LEN_W) ? ADDR_W : LEN_W)
                                             : ((DATA_W > LEN_W) ? DATA_W : LEN_W);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [1:0] OP_SET_WADDR  = 2'b00;
    localparam logic [1:0] OP_WRITE      = 2'b01;
    localparam logic [1:0] OP_SET_RADDR  = 2'b10;
    localparam logic [1:0] OP_READ_BURST = 2'b11;

    // One extra bit so MEM_DEPTH == 2^PAY_W is still representable.
    localparam logic [PAY_W:0]    DEPTH_P   = (PAY_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [LEN_W:0]    REM_ONE   = (LEN_W+1)'(1);

    // Address increment modulo MEM_DEPTH (not modulo 2^ADDR_W).
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        if (a == LAST_ADDR) begin
            r = {ADDR_W{1'b0}};
        end else begin
            r = a + ADDR_W'(1);
        end
        return r;
    endfunction

    logic [DATA_W-1:0] mem_r [MEM_DEPTH];

    logic [0:0]        state_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [LEN_W:0]    remaining_r;
    logic [DATA_W-1:0] dout_r;
    logic              tx_valid_r;
    logic              busy_r;
    logic              cmd_err_r;
    logic              cmd_drop_r;

    logic [1:0]        opcode_s;
    logic [PAY_W-1:0]  payload_s;
    logic              addr_ok_s;
    logic              mem_we_s;
    logic              handshake_s;

    // Command field decode, range check, memory write enable and handshake.
    always_comb begin
        opcode_s    = bus.din[PAY_W+1:PAY_W];
        payload_s   = bus.din[PAY_W-1:0];
        addr_ok_s   = ({1'b0, payload_s} < DEPTH_P);
        handshake_s = tx_valid_r & bus.tx_ready;
        if (rst_n && bus.rx_valid && (state_r == ST_IDLE) && (opcode_s == OP_WRITE)) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_addr_r] <= payload_s[DATA_W-1:0];
        end
    end

    // Control FSM, address registers, burst counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wr_addr_r   <= {ADDR_W{1'b0}};
            rd_addr_r   <= {ADDR_W{1'b0}};
            remaining_r <= {(LEN_W+1){1'b0}};
            dout_r      <= {DATA_W{1'b0}};
            tx_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            cmd_err_r   <= 1'b0;
            cmd_drop_r  <= 1'b0;
        end else begin
            cmd_err_r  <= 1'b0;
            cmd_drop_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        case (opcode_s)
                            OP_SET_WADDR: begin
                                if (addr_ok_s) begin
                                    wr_addr_r <= payload_s[ADDR_W-1:0];
                                end else begin
                                    cmd_err_r <= 1'b1;
                                end
                            end
                            OP_WRITE: begin
                                wr_addr_r <= wrap_inc(wr_addr_r);
                            end
                            OP_SET_RADDR: begin
                                if (addr_ok_s) begin
                                    rd_addr_r <= payload_s[ADDR_W-1:0];
                                end else begin
                                    cmd_err_r <= 1'b1;
                                end
                            end
                            OP_READ_BURST: begin
                                // First word is fetched immediately so data
                                // appears one cycle after the command strobe.
                                dout_r      <= mem_r[rd_addr_r];
                                tx_valid_r  <= 1'b1;
                                rd_addr_r   <= wrap_inc(rd_addr_r);
                                remaining_r <= {1'b0, payload_s[LEN_W-1:0]} + REM_ONE;
                                state_r     <= ST_SEND;
                                busy_r      <= 1'b1;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_SEND: begin
                    // Any command during a burst is rejected, including on the
                    // edge that completes the final handshake.
                    if (bus.rx_valid) begin
                        cmd_drop_r <= 1'b1;
                    end
                    if (handshake_s) begin
                        if (remaining_r == REM_ONE) begin
                            tx_valid_r <= 1'b0;
                            state_r    <= ST_IDLE;
                            busy_r     <= 1'b0;
                        end else begin
                            dout_r      <= mem_r[rd_addr_r];
                            rd_addr_r   <= wrap_inc(rd_addr_r);
                            remaining_r <= remaining_r - REM_ONE;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout     = dout_r;
    assign bus.tx_valid = tx_valid_r;
    assign bus.busy     = busy_r;
    assign bus.cmd_err  = cmd_err_r;
    assign bus.cmd_drop = cmd_drop_r;

endmodule

// File: tb/tb_spi_burst_ram.sv
// -----------------------------------------------------------------------------
// tb_spi_burst_ram
// Directed self-checking bench for spi_burst_ram (MEM_DEPTH = 200 so address
// wrap at a non-power-of-two depth is exercised). Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_spi_burst_ram;

    localparam logic [1:0] OP_SETW = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_SETR = 2'b10;
    localparam logic [1:0] OP_RD   = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    spi_burst_ram_if #(.DATA_W(8), .ADDR_W(8), .LEN_W(4)) bus ();

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .LEN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] pay);
        bus.din      = {op, pay};
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.din      = 10'd0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        vectors++; if (bus.dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.cmd_err !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_err got=%b exp=0", bus.cmd_err); end
        vectors++; if (bus.cmd_drop !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_drop got=%b exp=0", bus.cmd_drop); end
        // Single-word burst from address 0 after writing it.
        send_cmd(OP_SETW, 8'd0);
        send_cmd(OP_WR, 8'h5A);
        send_cmd(OP_SETR, 8'd0);
        bus.tx_ready = 1'b1;
        send_cmd(OP_RD, 8'd0);
        vectors++; if (bus.dout !== 8'h5A) begin miscompares++; $display("FAIL len0_dout got=%h exp=5a", bus.dout); end
        vectors++; if (bus.tx_valid !== 1'b1) begin miscompares++; $display("FAIL len0_tx_valid got=%b exp=1", bus.tx_valid); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL len0_busy got=%b exp=1", bus.busy); end
        step();
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL len0_end_tx_valid got=%b exp=0", bus.tx_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL len0_end_busy got=%b exp=0", bus.busy); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_burst();
        logic [7:0] exp [3];
        exp = '{8'hA1, 8'hB2, 8'hC3};
        send_cmd(OP_SETW, 8'h10);
        send_cmd(OP_WR, 8'hA1);
        send_cmd(OP_WR, 8'hB2);
        send_cmd(OP_WR, 8'hC3);
        send_cmd(OP_SETR, 8'h10);
        bus.tx_ready = 1'b1;
        send_cmd(OP_RD, 8'd2);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.dout !== exp[i]) begin miscompares++; $display("FAIL burst_dout[%0d] got=%h exp=%h", i, bus.dout, exp[i]); end
            vectors++; if (bus.tx_valid !== 1'b1) begin miscompares++; $display("FAIL burst_tx_valid[%0d] got=%b exp=1", i, bus.tx_valid); end
            step();
        end
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL burst_end_tx_valid got=%b exp=0", bus.tx_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL burst_end_busy got=%b exp=0", bus.busy); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp [3];
        exp = '{8'h11, 8'h22, 8'h33};
        send_cmd(OP_SETW, 8'd199);
        send_cmd(OP_WR, 8'h11);
        send_cmd(OP_WR, 8'h22);
        send_cmd(OP_SETW, 8'd200);
        vectors++; if (bus.cmd_err !== 1'b1) begin miscompares++; $display("FAIL err_pulse got=%b exp=1", bus.cmd_err); end
        step();
        vectors++; if (bus.cmd_err !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle got=%b exp=0", bus.cmd_err); end
        // wr_addr must still be 1: this lands at address 1.
        send_cmd(OP_WR, 8'h33);
        send_cmd(OP_SETR, 8'd255);
        vectors++; if (bus.cmd_err !== 1'b1) begin miscompares++; $display("FAIL raddr_err got=%b exp=1", bus.cmd_err); end
        send_cmd(OP_SETR, 8'd199);
        vectors++; if (bus.cmd_err !== 1'b0) begin miscompares++; $display("FAIL raddr_ok_err got=%b exp=0", bus.cmd_err); end
        bus.tx_ready = 1'b1;
        send_cmd(OP_RD, 8'd2);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.dout !== exp[i]) begin miscompares++; $display("FAIL wrap_dout[%0d] got=%h exp=%h", i, bus.dout, exp[i]); end
            step();
        end
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_end_tx_valid got=%b exp=0", bus.tx_valid); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic       pat  [6];
        logic [7:0] held [5];
        logic [7:0] exp  [4];
        logic [7:0] got  [$];
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        held = '{8'hB2, 8'hB2, 8'hB2, 8'hC3, 8'hD4};
        exp  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_cmd(OP_SETW, 8'h13);
        send_cmd(OP_WR, 8'hD4);
        send_cmd(OP_SETR, 8'h10);
        send_cmd(OP_RD, 8'd3);
        for (int i = 0; i < 6; i++) begin
            bus.tx_ready = pat[i];
            if (bus.tx_valid && bus.tx_ready) begin
                got.push_back(bus.dout);
            end
            step();
            if (i < 5) begin
                vectors++; if (bus.dout !== held[i]) begin miscompares++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, bus.dout, held[i]); end
            end
        end
        vectors++; if (got.size() != 4) begin miscompares++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, got[i], exp[i]); end
            end
        end
        step();
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle_tx_valid got=%b exp=0", bus.tx_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL bp_idle_busy got=%b exp=0", bus.busy); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_drop();
        logic [7:0] exp [4];
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_cmd(OP_WR, 8'hE5);          // lands at 0x14, wr_addr -> 0x15
        send_cmd(OP_SETR, 8'h10);
        send_cmd(OP_RD, 8'd3);
        send_cmd(OP_WR, 8'h55);          // must be dropped
        vectors++; if (bus.cmd_drop !== 1'b1) begin miscompares++; $display("FAIL drop_pulse got=%b exp=1", bus.cmd_drop); end
        vectors++; if (bus.dout !== 8'hA1) begin miscompares++; $display("FAIL drop_dout got=%h exp=a1", bus.dout); end
        vectors++; if (bus.tx_valid !== 1'b1) begin miscompares++; $display("FAIL drop_tx_valid got=%b exp=1", bus.tx_valid); end
        step();
        vectors++; if (bus.cmd_drop !== 1'b0) begin miscompares++; $display("FAIL drop_one_cycle got=%b exp=0", bus.cmd_drop); end
        for (int i = 0; i < 4; i++) begin
            bus.tx_ready = 1'b1;
            vectors++; if (bus.dout !== exp[i]) begin miscompares++; $display("FAIL drop_burst[%0d] got=%h exp=%h", i, bus.dout, exp[i]); end
            if (i == 3) begin
                // Command on the final handshake edge is still rejected.
                bus.din      = {OP_SETR, 8'h00};
                bus.rx_valid = 1'b1;
            end
            step();
            bus.rx_valid = 1'b0;
        end
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL drop_end_tx_valid got=%b exp=0", bus.tx_valid); end
        vectors++; if (bus.cmd_drop !== 1'b1) begin miscompares++; $display("FAIL drop_last_edge got=%b exp=1", bus.cmd_drop); end
        bus.tx_ready = 1'b0;
        send_cmd(OP_WR, 8'h66);          // lands at 0x15 if the drop left wr_addr alone
        bus.tx_ready = 1'b1;
        send_cmd(OP_RD, 8'd1);           // continues from 0x14
        vectors++; if (bus.dout !== 8'hE5) begin miscompares++; $display("FAIL drop_mem0 got=%h exp=e5", bus.dout); end
        step();
        vectors++; if (bus.dout !== 8'h66) begin miscompares++; $display("FAIL drop_mem1 got=%h exp=66", bus.dout); end
        step();
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL drop_final_tx_valid got=%b exp=0", bus.tx_valid); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        bus.tx_ready = 1'b1;
        send_cmd(OP_SETR, 8'h10);
        send_cmd(OP_RD, 8'd7);
        step();
        step();
        vectors++; if (bus.dout !== 8'hC3) begin miscompares++; $display("FAIL mid_dout got=%h exp=c3", bus.dout); end
        rst_n = 1'b0;
        step();
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_tx_valid got=%b exp=0", bus.tx_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.dout !== 8'h00) begin miscompares++; $display("FAIL mid_rst_dout got=%h exp=00", bus.dout); end
        rst_n = 1'b1;
        step();
        step();
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL mid_post_tx_valid got=%b exp=0", bus.tx_valid); end
        send_cmd(OP_RD, 8'd0);           // rd_addr back to 0 -> 0x22 from wrap test
        vectors++; if (bus.dout !== 8'h22) begin miscompares++; $display("FAIL mid_restart got=%h exp=22", bus.dout); end
        step();
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL mid_restart_end got=%b exp=0", bus.tx_valid); end
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_wrap();
        test_backpressure();
        test_drop();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_burst_ram.md
# spi_burst_ram

Parametrised command-driven single-port RAM behind the SPI slave. It decodes 2-bit opcode words from the SPI receive path. Writes auto-increment the address, so a stream of data words lands in consecutive locations. Reads run as multi-word bursts returned through a `tx_valid`/`tx_ready` handshake to the SPI transmit path. Out-of-range addresses and commands arriving during a burst are flagged, not silently absorbed.

## Interface
- `DATA_W`, 8, memory word width.
- `ADDR_W`, 8, address width.
- `MEM_DEPTH`, 256, number of words; must satisfy 2 ≤ `MEM_DEPTH` ≤ 2^`ADDR_W`.
- `LEN_W`, 4, burst-length field width; a burst is 1 to 2^`LEN_W` words.
- `PAY_W` (localparam) = max(`ADDR_W`, `DATA_W`, `LEN_W`), command payload width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  `PAY_W`+2  command word: [`PAY_W`+1:`PAY_W`] opcode, [`PAY_W`-1:0] payload.
- `rx_valid`  in  1  `din` valid this cycle (single-cycle strobe from SPI slave).
- `tx_ready`  in  1  SPI transmit side accepts `dout` this cycle.
- `dout`  out  `DATA_W`  read data.
- `tx_valid`  out  1  `dout` holds a valid burst word.
- `busy`  out  1  read burst in progress; high exactly when the FSM is in SEND.
- `cmd_err`  out  1  one-cycle pulse: address payload ≥ `MEM_DEPTH`.
- `cmd_drop`  out  1  one-cycle pulse: command rejected because `busy` was high.

## Operation
Internal state:
- Registers `wr_addr` and `rd_addr`, each `ADDR_W` bits.
- Burst counter `remaining`, `LEN_W`+1 bits.
- FSM with two states, IDLE and SEND.
- Memory contents are not reset.

Address increment is mod `MEM_DEPTH`: `MEM_DEPTH`-1 wraps to 0, not 2^`ADDR_W`.

Commands are sampled when `rx_valid`=1 and FSM=IDLE:
- 00 SET_WADDR:
  - If payload < `MEM_DEPTH`: `wr_addr` ← payload.
  - Otherwise: `wr_addr` unchanged and `cmd_err` pulses.
- 01 WRITE: `mem[wr_addr]` ← payload[`DATA_W`-1:0], then `wr_addr` ← wrap(`wr_addr`+1).
- 10 SET_RADDR: same rules as SET_WADDR, applied to `rd_addr`.
- 11 READ_BURST:
  - `dout` ← `mem[rd_addr]`, `tx_valid` ← 1.
  - `rd_addr` ← wrap(`rd_addr`+1).
  - `remaining` ← payload[`LEN_W`-1:0]+1.
  - FSM → SEND.

SEND:
- Handshake = `tx_valid` & `tx_ready` at a rising edge.
- On handshake with `remaining`=1: `tx_valid` ← 0, FSM → IDLE.
- On handshake with `remaining`>1:
  - `dout` ← `mem[rd_addr]`, `rd_addr` ← wrap(`rd_addr`+1), `remaining` −1.
  - `tx_valid` stays 1.
- With no handshake, `dout` and `tx_valid` hold.
- Any `rx_valid` while in SEND: command ignored, no state change, `cmd_drop` pulses.
- After a burst, `rd_addr` points one past the last word sent. A further READ_BURST continues sequentially.

Reset (`rst_n`=0 at an edge):
- `dout`=0, `tx_valid`=0, `busy`=0, `cmd_err`=0, `cmd_drop`=0.
- `wr_addr`=0, `rd_addr`=0, `remaining`=0, FSM=IDLE.
- Reset has priority over everything. A burst aborted by reset leaves `tx_valid` low from the next cycle and produces no further words.

## Timing
- Write path: command at edge k; `mem` and `wr_addr` are updated at edge k.
- Read latency: READ_BURST sampled at edge k; `dout`/`tx_valid`=1 visible after edge k. Data is available one cycle after the command strobe.
- Throughput: one word per cycle while `tx_ready` is held high. N words complete at edge k+N; `busy` falls after edge k+N.
- `busy` is registered and goes high after edge k.
- Commands are dropped if `rx_valid` arrives at any edge where FSM=SEND, including the edge on which the last handshake occurs. The first accepted command is at edge k+N+1.
- `cmd_err` and `cmd_drop` are registered and high for exactly one cycle after the offending edge.
- `tx_ready` while `tx_valid`=0 has no effect.

## Test plan
- Reset then idle → all outputs 0. READ_BURST len 0 from address 0 returns `mem[0]` (X-free after a prior write).
- SET_WADDR 0x10, WRITE 0xA1, 0xB2, 0xC3, SET_RADDR 0x10, READ_BURST payload 2 with `tx_ready`=1 → `dout` 0xA1, 0xB2, 0xC3 on three consecutive cycles; `tx_valid` then 0, `busy` 0.
- With `MEM_DEPTH`=200: SET_WADDR 199, WRITE 0x11, WRITE 0x22 → `mem[199]`=0x11, `mem[0]`=0x22. SET_WADDR 200 → `cmd_err` 1-cycle pulse, `wr_addr` stays 1.
- READ_BURST len 3 with `tx_ready` toggled 1,0,0,1,1,1 → each word held while `tx_ready`=0; exactly 4 words delivered, in order, no duplicates.
- WRITE 0x55 issued during a burst → `cmd_drop` pulse, memory unchanged. Burst output is unaffected.
- `rst_n`=0 asserted mid-burst after 2 of 8 words → `tx_valid`, `busy` = 0 after that edge. A later READ_BURST restarts from `rd_addr`=0.
